// File: rtl/logic_reduce_unit_pkg.sv
// Shared encodings for logic_reduce_unit: operation select, control-FSM states, NUM_IN limits.
// Pure declarations, no logic; imported by the core and the top level.
package logic_reduce_unit_pkg;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_XOR = 2'b10,
    OP_NOR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  localparam int NUM_IN_MIN = 2;
  localparam int NUM_IN_MAX = 8;

endpackage

// File: rtl/logic_reduce_core.sv
// logic_reduce_core: purely combinational bitwise AND/OR/XOR/NOR across NUM_IN packed operands.
// Zero latency, no flow control; zero flags an all-zeros result.
module logic_reduce_core
  import logic_reduce_unit_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 2
) (
  input  logic [NUM_IN*WIDTH-1:0] In,
  input  logic [1:0]              Op,
  output logic [WIDTH-1:0]        result,
  output logic                    zero
);

  logic [WIDTH-1:0] red_and;
  logic [WIDTH-1:0] red_or;
  logic [WIDTH-1:0] red_xor;

  always_comb begin
    red_and = '1;
    red_or  = '0;
    red_xor = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      red_and = red_and & In[k*WIDTH +: WIDTH];
      red_or  = red_or  | In[k*WIDTH +: WIDTH];
      red_xor = red_xor ^ In[k*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    result = red_or;
    case (op_e'(Op))
      OP_AND: result = red_and;
      OP_OR:  result = red_or;
      OP_XOR: result = red_xor;
      OP_NOR: result = ~red_or;
      default: result = red_or;
    endcase
    zero = ~|result;
  end

endmodule

// File: rtl/logic_reduce_unit.sv
// logic_reduce_unit: registered bitwise reduction, 1-cycle latency, valid/ready on input and output.
// Stalls input via InReady when the result cannot drain; macro LOGIC_REDUCE_SKID_EN adds a skid entry and registers InReady.
module logic_reduce_unit
  import logic_reduce_unit_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 2
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic [NUM_IN*WIDTH-1:0] In,
  input  logic [1:0]              Op,
  input  logic                    InValid,
  output logic                    InReady,
  output logic [WIDTH-1:0]        O,
  output logic                    Zero,
  output logic                    OutValid,
  input  logic                    OutReady
);

  generate
    if (NUM_IN < NUM_IN_MIN || NUM_IN > NUM_IN_MAX) begin : g_bad_num_in
      $error("logic_reduce_unit: NUM_IN must lie within 2..8");
    end
  endgenerate

  logic [WIDTH-1:0] red_res;
  logic             red_zero;

  logic_reduce_core #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN)
  ) u_core (
    .In     (In),
    .Op     (Op),
    .result (red_res),
    .zero   (red_zero)
  );

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic             zero_q, zero_d;
  logic             out_vld_q, out_vld_d;
  logic             in_fire;
  logic             out_fire;

`ifdef LOGIC_REDUCE_SKID_EN
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             skid_zero_q, skid_zero_d;
  logic             in_rdy_q, in_rdy_d;

  assign InReady = in_rdy_q;
`else
  // rdy_en_q keeps InReady low during reset and on the edge that releases it.
  logic rdy_en_q, rdy_en_d;

  assign InReady = rdy_en_q && (!out_vld_q || OutReady);
`endif

  assign in_fire  = InValid && InReady;
  assign out_fire = out_vld_q && OutReady;

  assign O        = main_q;
  assign Zero     = zero_q;
  assign OutValid = out_vld_q;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    zero_d  = zero_q;
`ifdef LOGIC_REDUCE_SKID_EN
    skid_d      = skid_q;
    skid_zero_d = skid_zero_q;
`else
    rdy_en_d = 1'b1;
`endif
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          main_d  = red_res;
          zero_d  = red_zero;
          state_d = ONE;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          main_d = red_res;
          zero_d = red_zero;
`ifdef LOGIC_REDUCE_SKID_EN
        end else if (in_fire) begin
          skid_d      = red_res;
          skid_zero_d = red_zero;
          state_d     = TWO;
`endif
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
`ifdef LOGIC_REDUCE_SKID_EN
      TWO: begin
        // The older result sits in main; on drain the skid entry takes its place.
        if (out_fire) begin
          main_d  = skid_q;
          zero_d  = skid_zero_q;
          state_d = ONE;
        end
      end
`endif
      default: state_d = EMPTY;
    endcase
    out_vld_d = (state_d != EMPTY);
`ifdef LOGIC_REDUCE_SKID_EN
    in_rdy_d = (state_d != TWO);
`endif
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q     <= EMPTY;
      main_q      <= '0;
      zero_q      <= 1'b0;
      out_vld_q   <= 1'b0;
`ifdef LOGIC_REDUCE_SKID_EN
      skid_q      <= '0;
      skid_zero_q <= 1'b0;
      in_rdy_q    <= 1'b0;
`else
      rdy_en_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      zero_q      <= zero_d;
      out_vld_q   <= out_vld_d;
`ifdef LOGIC_REDUCE_SKID_EN
      skid_q      <= skid_d;
      skid_zero_q <= skid_zero_d;
      in_rdy_q    <= in_rdy_d;
`else
      rdy_en_q    <= rdy_en_d;
`endif
    end
  end

endmodule
